// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder: turns one request (R/I/J/LI/NOP) into one or two
// encoded words on a valid/ready output stream, counting every word handed off.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [5:0]  in_op,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_sa,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic [15:0] count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holds its payload stable until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] second_q;
  logic [31:0] first_word;
  logic [31:0] second_word;
  logic        two_word;
  logic        illegal;
  logic        accept;
  logic        handoff;

  assign in_ready = (state == IDLE) || (state == EMIT1 && out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    first_word  = 32'h0;
    second_word = {6'b001101, in_rt, in_rt, in_imm[15:0]};
    two_word    = 1'b0;
    illegal     = 1'b0;
    case (in_kind)
      3'd0: first_word = {6'b000000, in_rs, in_rt, in_rd, in_sa, in_funct};
      3'd1: first_word = {in_op, in_rs, in_rt, in_imm[15:0]};
      3'd2: first_word = {in_op, in_imm[25:0]};
      3'd3: begin
        // LI collapses to one instruction whenever one half is zero.
        if (in_imm[31:16] == 16'h0) begin
          first_word = {6'b001101, 5'd0, in_rt, in_imm[15:0]};
        end else if (in_imm[15:0] == 16'h0) begin
          first_word = {6'b001111, 5'd0, in_rt, in_imm[31:16]};
        end else begin
          first_word = {6'b001111, 5'd0, in_rt, in_imm[31:16]};
          two_word   = 1'b1;
        end
      end
      3'd4:    first_word = 32'h0;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      count     <= 16'h0;
      second_q  <= 32'h0;
    end else begin
      err <= 1'b0;
      if (handoff) begin
        count <= count + 16'd1;
      end
      if (accept) begin
        if (illegal) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          err       <= 1'b1;
        end else if (two_word) begin
          state     <= EMIT2;
          out_valid <= 1'b1;
          out_inst  <= first_word;
          out_last  <= 1'b0;
          second_q  <= second_word;
        end else begin
          state     <= EMIT1;
          out_valid <= 1'b1;
          out_inst  <= first_word;
          out_last  <= 1'b1;
        end
      end else if (handoff) begin
        if (state == EMIT2) begin
          state    <= EMIT1;
          out_inst <= second_q;
          out_last <= 1'b1;
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed cases for the documented examples, then
// random requests with random back-pressure, checked against a word-queue model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [5:0]  in_op = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_sa = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_last;
  logic        busy;
  logic        err;
  logic [15:0] count;

  int n_checks = 0;
  int n_fail = 0;
  logic        rand_rdy = 1'b0;
  logic [32:0] exp_q[$];   // {last, word} still owed by the DUT
  logic [15:0] exp_count = '0;
  logic        err_exp = 1'b0;

  inst_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_last(out_last), .busy(busy), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the list of words a request must produce, from the encoding rules.
  function automatic void model_push(input logic [2:0] k, input logic [5:0] op,
                                     input logic [5:0] fn, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sa, input logic [31:0] imm);
    logic [31:0] hi, lo;
    hi = imm >> 16;
    lo = imm & 32'hFFFF;
    case (k)
      3'd0: exp_q.push_back({1'b1, (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(fn)});
      3'd1: exp_q.push_back({1'b1, (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo});
      3'd2: exp_q.push_back({1'b1, (32'(op) << 26) | (imm & 32'h03FF_FFFF)});
      3'd3: begin
        if (hi == 0) exp_q.push_back({1'b1, (32'd13 << 26) | (32'(rt) << 16) | lo});
        else if (lo == 0) exp_q.push_back({1'b1, (32'd15 << 26) | (32'(rt) << 16) | hi});
        else begin
          exp_q.push_back({1'b0, (32'd15 << 26) | (32'(rt) << 16) | hi});
          exp_q.push_back({1'b1, (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | lo});
        end
      end
      default: exp_q.push_back({1'b1, 32'h0});
    endcase
  endfunction

  // Monitor samples mid-cycle; inputs only change just after rising edges.
  always @(negedge clk) begin
    logic mready;
    if (rst) begin
      exp_q.delete();
      exp_count = '0;
      err_exp = 1'b0;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_count", 32'(count), 0);
    end else begin
      mready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("err", 32'(err), 32'(err_exp));
      check("count", 32'(count), 32'(exp_count));
      check("in_ready", 32'(in_ready), 32'(mready));
      if (exp_q.size() != 0) begin
        check("out_inst", out_inst, exp_q[0][31:0]);
        check("out_last", 32'(out_last), 32'(exp_q[0][32]));
      end
      err_exp = 1'b0;
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        exp_count++;
      end
      if (in_valid && mready) begin
        if (in_kind > 3'd4) err_exp = 1'b1;
        else model_push(in_kind, in_op, in_funct, in_rs, in_rt, in_rd, in_sa, in_imm);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Returns at edge+1 of the accepting edge, with in_valid dropped.
  task automatic send(input logic [2:0] k, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sa, input logic [31:0] imm);
    logic acc;
    acc = 1'b0;
    in_kind = k; in_op = op; in_funct = fn; in_rs = rs; in_rt = rt;
    in_rd = rd; in_sa = sa; in_imm = imm; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 32'(acc), 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    step();
    check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    repeat (3) step();
    check("reset_inst", out_inst, 0);
    check("reset_err", 32'(err), 0);
    rst = 1'b0;
    check("ready_after_rst", 32'(in_ready), 1);

    out_ready = 1'b1;
    send(3'd0, 6'h0, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    check("r_word", out_inst, 32'h00221820);
    check("r_last", 32'(out_last), 1);
    drain();
    check("r_count", 32'(count), 1);

    send(3'd3, 6'h0, 6'h0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
    in_rt = 5'd31; in_imm = 32'hFFFF_FFFF;
    check("li_lui", out_inst, 32'h3C081234);
    check("li_lui_last", 32'(out_last), 0);
    step();
    check("li_ori", out_inst, 32'h35085678);
    check("li_ori_last", 32'(out_last), 1);
    drain();
    check("li_count", 32'(count), 3);

    send(3'd3, 6'h0, 6'h0, 5'd0, 5'd9, 5'd0, 5'd0, 32'h00001234);
    check("li_ori_only", out_inst, 32'h34091234);
    check("li_ori_only_last", 32'(out_last), 1);
    send(3'd3, 6'h0, 6'h0, 5'd0, 5'd9, 5'd0, 5'd0, 32'hABCD0000);
    check("li_lui_only", out_inst, 32'h3C09ABCD);
    check("li_lui_only_last", 32'(out_last), 1);
    drain();

    out_ready = 1'b0;
    send(3'd2, 6'h02, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("j_hold", out_inst, 32'h08000100);
      check("j_hold_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("j_gone", 32'(out_valid), 0);
    check("j_count", 32'(count), 6);

    send(3'd6, 6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    check("ill_err", 32'(err), 1);
    check("ill_valid", 32'(out_valid), 0);
    step();
    check("ill_err_drop", 32'(err), 0);
    check("ill_count", 32'(count), 6);

    out_ready = 1'b0;
    send(3'd3, 6'h0, 6'h0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_inst", out_inst, 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_count", 32'(count), 0);
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("ready_after_rst2", 32'(in_ready), 1);
    repeat (4) step();
    check("no_ori_after_rst", 32'(out_valid), 0);

    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] imm;
      imm = $urandom;
      case ($urandom_range(0, 2))
        0: imm = imm & 32'h0000_FFFF;
        1: imm = imm & 32'hFFFF_0000;
        default: ;
      endcase
      send(3'($urandom_range(0, 7)), 6'($urandom), 6'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), imm);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  request present.
REQ-004 in_ready  output  1  request accepted when in_valid&&in_ready at a rising edge.
REQ-005 in_kind  input  3  0=R-type, 1=I-type, 2=J-type, 3=LI pseudo, 4=NOP, 5..7 illegal.
REQ-006 in_op  input  6  opcode field; ignored for kinds 0, 3 and 4.
REQ-007 in_funct  input  6  funct field, used only by kind 0.
REQ-008 in_rs, in_rt, in_rd, in_sa  input  5 each  register/shift fields; LI destination is in_rt.
REQ-009 in_imm  input  32  kind 1 uses [15:0], kind 2 uses [25:0], kind 3 uses [31:0].
REQ-010 out_valid  output  1  out_inst holds a valid encoded word.
REQ-011 out_ready  input  1  consumer takes word when out_valid&&out_ready.
REQ-012 out_inst  output  32  encoded MIPS32 instruction.
REQ-013 out_last  output  1  word is final word of its request.
REQ-014 busy  output  1  state != IDLE.
REQ-015 err  output  1  one-cycle pulse on illegal kind.
REQ-016 count  output  16  number of words handed off; wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states SHALL be IDLE, EMIT1 (presenting sole/final word), EMIT2 (presenting first of two words).
REQ-018 Encodings: R={6'b0,rs,rt,rd,sa,funct}; I={op,rs,rt,imm[15:0]}; J={op,imm[25:0]}; NOP=32'h0.
REQ-019 LI: imm[31:16]==0 -> single ORI {6'b001101,5'd0,rt,imm[15:0]}; else imm[15:0]==0 -> single LUI {6'b001111,5'd0,rt,imm[31:16]}; else LUI then ORI {6'b001101,rt,rt,imm[15:0]}.
REQ-020 Latency: request accepted at edge N -> out_valid high after edge N (registered output), first word visible the following cycle.
REQ-021 Single-word request SHALL go IDLE->EMIT1 with out_last=1; two-word LI SHALL go IDLE->EMIT2 (out_last=0), then on handoff ->EMIT1 with ORI word, out_last=1.
REQ-022 out_inst, out_last SHALL remain stable while out_valid && !out_ready.
REQ-023 in_ready = (state==IDLE) || (state==EMIT1 && out_ready); back-to-back requests SHALL sustain one word per cycle.
REQ-024 On final-word handoff with no new accept, FSM SHALL return to IDLE and deassert out_valid.
REQ-025 Second LI word's fields SHALL come from a register captured at accept time, independent of later input changes.
REQ-026 Illegal kind: request accepted, no word emitted, err=1 for exactly the next cycle, FSM stays/returns IDLE, count unchanged.
REQ-027 count SHALL increment by 1 on each out_valid&&out_ready edge.
REQ-028 No combinational path from in_* to out_*; out_ready->in_ready path is permitted.

Reset
REQ-029 On rst asserted, immediately: state=IDLE, out_valid=0, out_inst=0, out_last=0, err=0, count=0, busy=0.
REQ-030 rst mid-request (including between LI words) SHALL discard pending words; nothing emitted after release until a new accept.
REQ-031 in_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-032 kind 0, rs=1,rt=2,rd=3,sa=0,funct=6'h20, out_ready=1 -> one word 0x00221820, out_last=1, count=1.
REQ-033 kind 3, rt=8, imm=0x12345678 -> 0x3C081234 (last=0) then 0x35085678 (last=1); count +2.
REQ-034 kind 3, rt=9, imm=0x00001234 -> single 0x34091234; kind 3, rt=9, imm=0xABCD0000 -> single 0x3C09ABCD.
REQ-035 kind 2, op=6'h02, imm=0x100 with out_ready low 3 cycles -> 0x08000100 held stable, in_ready=0, then handed off once.
REQ-036 kind 6 -> err pulse 1 cycle, no out_valid, count unchanged; rst asserted after first LI word of 0x12345678 -> out_valid=0 immediately, ORI word never appears.
